// File: rtl/cfg_bus_arb_if.sv
// rtl/cfg_bus_arb_if.sv - requester-side and downstream-side cfg-bus signals of cfg_bus_arb
interface cfg_bus_arb_if #(
  parameter int NUM_REQ = 2
);
  // requester side: packed per-requester slices, slice i = [32i+31:32i]
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ-1:0]    req_rd;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           req_rdata;

  // shared downstream slave
  logic [31:0]           ds_addr;
  logic [31:0]           ds_wdata;
  logic                  ds_wr;
  logic                  ds_rd;
  logic                  ds_ack;
  logic [31:0]           ds_rdata;

  // status
  logic [NUM_REQ-1:0]    ovf_err;
  logic [15:0]           timeout_cnt;

  // arbiter view
  modport slave (
    input  req_addr, req_wdata, req_wr, req_rd, ds_ack, ds_rdata,
    output req_ack, req_rdata, ds_addr, ds_wdata, ds_wr, ds_rd, ovf_err, timeout_cnt
  );

  // requesters plus downstream model view
  modport master (
    output req_addr, req_wdata, req_wr, req_rd, ds_ack, ds_rdata,
    input  req_ack, req_rdata, ds_addr, ds_wdata, ds_wr, ds_rd, ovf_err, timeout_cnt
  );
endinterface

// File: rtl/cfg_bus_arb.sv
// rtl/cfg_bus_arb.sv - round-robin arbiter sharing one cfg-bus slave among NUM_REQ requesters
module cfg_bus_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         sync_rst_n,
  input  logic         sh_cl_flr_assert,
  cfg_bus_arb_if.slave bus
);

  localparam int                PTR_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                TCNT_W        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST     = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]       TIMEOUT_RDATA = 32'hdead_beef;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [NUM_REQ-1:0] r_pending;
  logic [31:0]        r_slot_addr  [NUM_REQ];
  logic [31:0]        r_slot_wdata [NUM_REQ];
  logic [NUM_REQ-1:0] r_slot_wr;

  logic [NUM_REQ-1:0] w_pulse;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_accept;
  logic [NUM_REQ-1:0] w_drop;

  logic [PTR_W-1:0]   r_rr;
  logic [PTR_W-1:0]   r_grant;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_grant_next;
  logic               w_any_pend;
  logic               w_issue;
  logic               w_done;
  logic               w_tmo;

  logic [TCNT_W-1:0]  r_tcnt;
  logic               r_ds_wr;
  logic               r_ds_rd;
  logic [31:0]        r_ds_addr;
  logic [31:0]        r_ds_wdata;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [31:0]        r_req_rdata;
  logic [NUM_REQ-1:0] r_ovf_err;
  logic [15:0]        r_timeout_cnt;

  // index base+off modulo NUM_REQ, valid for off < NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = {{(32-PTR_W){1'b0}}, base} + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  assign w_pulse      = bus.req_wr | bus.req_rd;
  assign w_grant_oh   = NUM_REQ'(1) << r_grant;
  assign w_grant_next = wrap_add(r_grant, 1);
  assign w_clr        = w_done ? w_grant_oh : '0;
  assign w_accept     = w_pulse & (~r_pending | w_clr);
  assign w_drop       = w_pulse & r_pending & ~w_clr;
  assign w_issue      = (r_state == S_IDLE) && w_any_pend;

  // pick the pending slot closest to r_rr going upward with wrap; nearest one overwrites last
  always_comb begin
    w_any_pend = 1'b0;
    w_pick     = r_rr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (r_pending[wrap_add(r_rr, k)]) begin
        w_any_pend = 1'b1;
        w_pick     = wrap_add(r_rr, k);
      end
    end
  end

  // next state and completion decode; an ack beats a timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_pend) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.ds_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ds_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tcnt == TCNT_LAST) begin
          w_done      = 1'b1;
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register; FLR returns to IDLE so a late downstream ack falls on the floor
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_state <= S_IDLE;
    end else if (sh_cl_flr_assert) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // grant latch, one-cycle downstream strobe, wait counter and completion return
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_grant     <= '0;
      r_rr        <= '0;
      r_tcnt      <= '0;
      r_ds_wr     <= 1'b0;
      r_ds_rd     <= 1'b0;
      r_ds_addr   <= '0;
      r_ds_wdata  <= '0;
      r_req_ack   <= '0;
      r_req_rdata <= '0;
    end else if (sh_cl_flr_assert) begin
      r_grant     <= '0;
      r_rr        <= '0;
      r_tcnt      <= '0;
      r_ds_wr     <= 1'b0;
      r_ds_rd     <= 1'b0;
      r_ds_addr   <= '0;
      r_ds_wdata  <= '0;
      r_req_ack   <= '0;
      r_req_rdata <= '0;
    end else begin
      r_ds_wr   <= 1'b0;
      r_ds_rd   <= 1'b0;
      r_req_ack <= '0;
      if (w_issue) begin
        r_grant    <= w_pick;
        r_ds_addr  <= r_slot_addr[w_pick];
        r_ds_wdata <= r_slot_wdata[w_pick];
        r_ds_wr    <= r_slot_wr[w_pick];
        r_ds_rd    <= !r_slot_wr[w_pick];
      end
      r_tcnt <= ((r_state == S_WAIT) && !w_done) ? r_tcnt + 1'b1 : '0;
      if (w_done) begin
        r_req_ack   <= w_grant_oh;
        r_req_rdata <= w_tmo ? TIMEOUT_RDATA : bus.ds_rdata;
        r_rr        <= w_grant_next;
      end
    end
  end

  // 1-deep pending slots: completion frees a slot and a pulse on that same edge refills it
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_pending <= '0;
      r_slot_wr <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot_addr[i]  <= '0;
        r_slot_wdata[i] <= '0;
      end
    end else if (sh_cl_flr_assert) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_accept;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_slot_addr[i]  <= bus.req_addr[32*i +: 32];
          r_slot_wdata[i] <= bus.req_wdata[32*i +: 32];
          r_slot_wr[i]    <= bus.req_wr[i];
        end
      end
    end
  end

  // sticky overflow flags and saturating timeout count keep their value across FLR
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_ovf_err     <= '0;
      r_timeout_cnt <= '0;
    end else if (!sh_cl_flr_assert) begin
      r_ovf_err <= r_ovf_err | w_drop;
      if (w_tmo && (r_timeout_cnt != 16'hffff)) r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end

  assign bus.ds_addr     = r_ds_addr;
  assign bus.ds_wdata    = r_ds_wdata;
  assign bus.ds_wr       = r_ds_wr;
  assign bus.ds_rd       = r_ds_rd;
  assign bus.req_ack     = r_req_ack;
  assign bus.req_rdata   = r_req_rdata;
  assign bus.ovf_err     = r_ovf_err;
  assign bus.timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_cfg_bus_arb.sv
// tb/tb_cfg_bus_arb.sv - directed and randomized self-checking bench for cfg_bus_arb
module tb_cfg_bus_arb;

  localparam int NR = 3;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic sync_rst_n;
  logic flr;

  always #5 clk = ~clk;

  cfg_bus_arb_if #(.NUM_REQ(NR)) bus ();

  cfg_bus_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .sync_rst_n       (sync_rst_n),
    .sh_cl_flr_assert (flr),
    .bus              (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus applied before the next rising edge
  logic [NR-1:0] d_wr, d_rd;
  logic [31:0]   d_addr [NR];
  logic [31:0]   d_wdata [NR];
  logic          d_ack, d_flr;
  logic [31:0]   d_rdata;

  // transaction-level reference: slots, outstanding transaction, edge bookkeeping
  int            m_k, m_free_at, m_g, m_cur, m_rr;
  bit            m_out;
  bit            m_pend [NR];
  bit            m_wr [NR];
  logic [31:0]   m_addr [NR];
  logic [31:0]   m_wdata [NR];
  logic [NR-1:0] e_ack, e_ovf;
  logic          e_wr, e_rd;
  logic [31:0]   e_addr, e_wdata, e_rdata;
  logic [15:0]   e_tcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pend0 [NR];
    bit clr [NR];
    int i;
    m_k++;
    e_ack = '0;
    e_wr  = 1'b0;
    e_rd  = 1'b0;
    if (d_flr) begin
      for (int j = 0; j < NR; j++) m_pend[j] = 1'b0;
      m_out = 1'b0; m_rr = 0; m_free_at = m_k + 1;
      e_rdata = '0; e_addr = '0; e_wdata = '0;
      return;
    end
    pend0 = m_pend;
    for (int j = 0; j < NR; j++) clr[j] = 1'b0;
    if (m_out && m_k > m_g) begin
      if (d_ack || m_k == m_g + 1 + T) begin
        e_ack[m_cur] = 1'b1;
        if (d_ack) e_rdata = d_rdata;
        else begin
          e_rdata = 32'hdead_beef;
          if (e_tcnt != 16'hffff) e_tcnt++;
        end
        clr[m_cur] = 1'b1; m_pend[m_cur] = 1'b0;
        m_rr = (m_cur + 1) % NR; m_out = 1'b0; m_free_at = m_k + 1;
      end
    end else if (!m_out && m_k >= m_free_at) begin
      for (int d = 0; d < NR; d++) begin
        i = (m_rr + d) % NR;
        if (pend0[i] && !m_out) begin
          m_out = 1'b1; m_g = m_k; m_cur = i;
          e_wr = m_wr[i]; e_rd = !m_wr[i]; e_addr = m_addr[i]; e_wdata = m_wdata[i];
        end
      end
    end
    for (int j = 0; j < NR; j++) begin
      if (d_wr[j] || d_rd[j]) begin
        if (!pend0[j] || clr[j]) begin
          m_pend[j] = 1'b1; m_addr[j] = d_addr[j]; m_wdata[j] = d_wdata[j]; m_wr[j] = d_wr[j];
        end else begin
          e_ovf[j] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("ds_wr",       32'(bus.ds_wr),       32'(e_wr));
    chk("ds_rd",       32'(bus.ds_rd),       32'(e_rd));
    chk("ds_addr",     bus.ds_addr,          e_addr);
    chk("ds_wdata",    bus.ds_wdata,         e_wdata);
    chk("req_ack",     32'(bus.req_ack),     32'(e_ack));
    chk("req_rdata",   bus.req_rdata,        e_rdata);
    chk("ovf_err",     32'(bus.ovf_err),     32'(e_ovf));
    chk("timeout_cnt", 32'(bus.timeout_cnt), 32'(e_tcnt));
  endtask

  task automatic step();
    @(negedge clk);
    bus.req_wr   = d_wr;
    bus.req_rd   = d_rd;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[32*i +: 32]  = d_addr[i];
      bus.req_wdata[32*i +: 32] = d_wdata[i];
    end
    bus.ds_ack   = d_ack;
    bus.ds_rdata = d_rdata;
    flr          = d_flr;
    @(posedge clk);
    model_edge();
    #1;
    compare();
    d_wr = '0; d_rd = '0; d_ack = 1'b0; d_flr = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.ds_wr || bus.ds_rd) && n < 12);
    chk("strobe_seen", 32'(bus.ds_wr | bus.ds_rd), 32'd1);
  endtask

  task automatic xact(input int idx, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    int n;
    if (wr) d_wr[idx] = 1'b1; else d_rd[idx] = 1'b1;
    d_addr[idx] = addr; d_wdata[idx] = wdata;
    step();
    wait_strobe(n);
    chk("x_addr", bus.ds_addr, addr);
    d_ack = 1'b1; d_rdata = rdata;
    step();
    chk("x_ack", 32'(bus.req_ack), 32'(1 << idx));
    chk("x_rdata", bus.req_rdata, rdata);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, strobes, r;

    sync_rst_n = 1'b0; flr = 1'b0;
    bus.req_wr = '0; bus.req_rd = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ds_ack = 1'b0; bus.ds_rdata = '0;
    d_wr = '0; d_rd = '0; d_ack = 1'b0; d_flr = 1'b0; d_rdata = '0;
    for (int i = 0; i < NR; i++) begin
      d_addr[i] = '0; d_wdata[i] = '0; m_pend[i] = 1'b0; m_wr[i] = 1'b0;
      m_addr[i] = '0; m_wdata[i] = '0;
    end
    m_k = 0; m_free_at = 0; m_g = 0; m_cur = 0; m_rr = 0; m_out = 1'b0;
    e_ack = '0; e_ovf = '0; e_wr = 1'b0; e_rd = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_tcnt = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    sync_rst_n = 1'b1;

    // single read, ack three cycles after the ds_rd cycle
    d_rd[0] = 1'b1; d_addr[0] = 32'h104;
    step();
    step();
    chk("t1_ds_rd", 32'(bus.ds_rd), 32'd1);
    chk("t1_ds_addr", bus.ds_addr, 32'h104);
    step();
    chk("t1_ds_rd_one_cycle", 32'(bus.ds_rd), 32'd0);
    step(); step();
    d_ack = 1'b1; d_rdata = 32'h1234_5678;
    step();
    chk("t1_req_ack", 32'(bus.req_ack), 32'b001);
    chk("t1_rdata", bus.req_rdata, 32'h1234_5678);
    step();
    chk("t1_ack_one_cycle", 32'(bus.req_ack), 32'd0);

    // move the round-robin pointer to 0, then a simultaneous pair
    xact(2, 1'b1, 32'h200, 32'h2, 32'h0);
    d_wr[0] = 1'b1; d_addr[0] = 32'h10; d_wdata[0] = 32'hA;
    d_rd[1] = 1'b1; d_addr[1] = 32'h20;
    step();
    wait_strobe(n);
    chk("t2_first_wr", 32'(bus.ds_wr), 32'd1);
    chk("t2_first_addr", bus.ds_addr, 32'h10);
    chk("t2_first_wdata", bus.ds_wdata, 32'hA);
    d_ack = 1'b1; d_rdata = 32'h0;
    step();
    chk("t2_first_ack", 32'(bus.req_ack), 32'b001);
    wait_strobe(n);
    chk("t2_gap", 32'(n), 32'd1);
    chk("t2_second_rd", 32'(bus.ds_rd), 32'd1);
    chk("t2_second_addr", bus.ds_addr, 32'h20);
    d_ack = 1'b1; d_rdata = 32'h5555_aaaa;
    step();
    chk("t2_second_ack", 32'(bus.req_ack), 32'b010);
    chk("t2_second_rdata", bus.req_rdata, 32'h5555_aaaa);
    step();

    // pointer to 1, then the same pair: requester 1 first, then wrap to 0
    xact(0, 1'b0, 32'h300, 32'h0, 32'h3333);
    d_wr[0] = 1'b1; d_addr[0] = 32'h10; d_wdata[0] = 32'hA;
    d_rd[1] = 1'b1; d_addr[1] = 32'h20;
    step();
    wait_strobe(n);
    chk("t2r_first_addr", bus.ds_addr, 32'h20);
    d_ack = 1'b1;
    step();
    chk("t2r_first_ack", 32'(bus.req_ack), 32'b010);
    wait_strobe(n);
    chk("t2r_second_addr", bus.ds_addr, 32'h10);
    d_ack = 1'b1;
    step();
    chk("t2r_second_ack", 32'(bus.req_ack), 32'b001);
    step();

    // timeout with no downstream ack, then a late ack that must be ignored
    d_rd[1] = 1'b1; d_addr[1] = 32'h30;
    step();
    wait_strobe(n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.req_ack == '0 && n < T + 10);
    chk("t3_wait_len", 32'(n), 32'(T + 1));
    chk("t3_ack", 32'(bus.req_ack), 32'b010);
    chk("t3_rdata", bus.req_rdata, 32'hdead_beef);
    chk("t3_tcnt", 32'(bus.timeout_cnt), 32'd1);
    repeat (4) step();
    d_ack = 1'b1; d_rdata = 32'h9999_9999;
    step();
    chk("t3_late_ack", 32'(bus.req_ack), 32'd0);
    step();
    chk("t3_late_ack2", 32'(bus.req_ack), 32'd0);

    // overflow while stalled, then a re-pulse on the ack edge
    d_wr[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h4444;
    step();
    step();
    chk("t4_first_wr", 32'(bus.ds_wr), 32'd1);
    strobes = 1;
    d_wr[0] = 1'b1; d_addr[0] = 32'h41; d_wdata[0] = 32'h4141;
    step();
    chk("t4_ovf", 32'(bus.ovf_err), 32'b001);
    repeat (3) begin
      step();
      strobes += int'(bus.ds_wr);
    end
    d_ack = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 32'h44; d_wdata[0] = 32'h4545;
    step();
    chk("t4_ack", 32'(bus.req_ack), 32'b001);
    chk("t4_single_wr", 32'(strobes), 32'd1);
    wait_strobe(n);
    chk("t4_second_wr", 32'(bus.ds_wr), 32'd1);
    chk("t4_second_addr", bus.ds_addr, 32'h44);
    chk("t4_second_wdata", bus.ds_wdata, 32'h4545);
    d_ack = 1'b1;
    step();
    step();

    // ack in the issue cycle itself
    d_rd[2] = 1'b1; d_addr[2] = 32'h50;
    step();
    wait_strobe(n);
    d_ack = 1'b1; d_rdata = 32'hCAFE_0050;
    step();
    chk("t5_ack", 32'(bus.req_ack), 32'b100);
    chk("t5_rdata", bus.req_rdata, 32'hCAFE_0050);
    chk("t5_tcnt", 32'(bus.timeout_cnt), 32'd1);
    step();
    chk("t5_no_reissue", 32'(bus.ds_rd | bus.ds_wr), 32'd0);

    // FLR during WAIT with another slot pending
    d_rd[0] = 1'b1; d_addr[0] = 32'h60;
    step();
    wait_strobe(n);
    step(); step();
    d_rd[1] = 1'b1; d_addr[1] = 32'h70;
    step(); step();
    d_flr = 1'b1;
    step();
    chk("t6_ack", 32'(bus.req_ack), 32'd0);
    chk("t6_ds_addr", bus.ds_addr, 32'd0);
    chk("t6_ovf_kept", 32'(bus.ovf_err), 32'b001);
    chk("t6_tcnt_kept", 32'(bus.timeout_cnt), 32'd1);
    repeat (3) begin
      step();
      chk("t6_idle", 32'(bus.ds_rd | bus.ds_wr | (|bus.req_ack)), 32'd0);
    end
    d_ack = 1'b1;
    step();
    chk("t6_late_ack", 32'(bus.req_ack), 32'd0);
    xact(0, 1'b0, 32'h80, 32'h0, 32'h8080_8080);
    chk("t6_ovf_after", 32'(bus.ovf_err), 32'b001);
    chk("t6_tcnt_after", 32'(bus.timeout_cnt), 32'd1);

    // randomized traffic against the reference
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        r = int'($urandom_range(0, 29));
        if (r <= 2) begin
          d_wr[i] = (r != 1);
          d_rd[i] = (r != 0);
          d_addr[i] = $urandom;
          d_wdata[i] = $urandom;
        end
      end
      d_ack   = ($urandom_range(0, 99) < 18);
      d_rdata = $urandom;
      d_flr   = ($urandom_range(0, 299) == 0);
      if (d_flr) begin
        d_wr = '0; d_rd = '0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_bus_arb.md
Name: cfg_bus_arb

Overview:
- Shares one downstream cfg-bus slave (addr/wdata/wr/rd pulse, ack/rdata return) between NUM_REQ cfg-bus requesters, for example the OCL register slave and a DMA/test sequencer.
- Captures each requester's 1-cycle wr/rd pulse into a 1-deep pending slot.
- Grants round-robin and issues one transaction at a time downstream.
- Returns ack/rdata to the winner; a timeout completes stalled transactions with 32'hdead_beef.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 256, WAIT-state cycles before forced completion (>=2)

Ports:
clk  in  1  clock
sync_rst_n  in  1  reset: asynchronous, active-low
sh_cl_flr_assert  in  1  function-level reset; aborts everything synchronously
req_addr  in  NUM_REQ*32  per-requester address, slice i = [32i+31:32i]
req_wdata  in  NUM_REQ*32  per-requester write data
req_wr  in  NUM_REQ  1-cycle write pulse
req_rd  in  NUM_REQ  1-cycle read pulse
req_ack  out  NUM_REQ  1-cycle completion pulse
req_rdata  out  32  read data, valid with any req_ack bit
ds_addr  out  32  downstream address
ds_wdata  out  32  downstream write data
ds_wr  out  1  downstream write pulse
ds_rd  out  1  downstream read pulse
ds_ack  in  1  downstream completion
ds_rdata  in  32  downstream read data, valid with ds_ack
ovf_err  out  NUM_REQ  sticky: pulse arrived while slot occupied
timeout_cnt  out  16  saturating count of timed-out transactions

Behaviour:
- Reset (async) and flr: all outputs 0, state IDLE, pending slots empty, rr pointer 0, timeout counter 0.
- FLR exception: ovf_err and timeout_cnt hold their values (cleared only by sync_rst_n).
- Capture: on a clock edge with req_wr[i] or req_rd[i], slot i latches addr, wdata and is_wr (wr wins if both are set).
- Slot update: pending_nxt = (pending & ~clr) | pulse.
  - A pulse on the same edge that clears slot i is accepted.
  - A pulse while slot i is busy and not clearing is dropped and sets ovf_err[i].
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if any slot is pending, grant the first pending index at or after rr_ptr (wrapping). Latch grant, ds_addr, ds_wdata, is_wr. Go to ISSUE.
  - ISSUE (exactly 1 cycle): ds_wr = is_wr, ds_rd = !is_wr. Go to WAIT, unless ds_ack is sampled this cycle, in which case complete.
  - WAIT: ds_wr/ds_rd = 0. Timeout counter increments each cycle.
    - ds_ack sampled: complete.
    - Counter reaches TIMEOUT_CYCLES-1 without ack: complete with timeout.
  - Complete (registered): on the next cycle req_ack[grant] = 1 for one cycle.
    - req_rdata = ds_rdata for an ack, 32'hdead_beef for a timeout.
    - Timeout also increments timeout_cnt, saturating at 16'hffff.
    - Clear slot[grant], rr_ptr = grant+1 mod NUM_REQ, state IDLE.
- Latency: pulse at edge N → ds_wr/ds_rd high in the cycle after edge N+1 (assuming idle) → with ds_ack at edge M, req_ack in the cycle after edge M.
- Minimum gap between back-to-back transactions: 1 IDLE cycle.
- ds_ack while IDLE (late ack after timeout) is ignored.
- ds_addr/ds_wdata hold their last value between transactions.
- req_rdata holds until the next completion.
- Writes return req_rdata = ds_rdata as sampled (don't care to requesters).
- FLR mid-transaction: no req_ack is generated; the downstream ack, if it arrives later, is ignored.

Test Plan:
- Single read: req_rd[0] with addr 0x104; ds_ack 3 cycles after ds_rd with rdata 0x1234_5678 → ds_rd one cycle with ds_addr 0x104; req_ack[0] one cycle later with req_rdata 0x1234_5678; req_ack[1] stays 0.
- Simultaneous requests: req_wr[0] (addr 0x10, wdata 0xA) and req_rd[1] (addr 0x20) on the same edge, immediate acks → req0 write issued first, then req1 read. Repeating the pair from rr_ptr=1 → req1 first.
- Timeout: req_rd[1], ds_ack never asserted → req_ack[1] after TIMEOUT_CYCLES WAIT cycles with req_rdata 0xdead_beef; timeout_cnt = 1. An ack injected 5 cycles later → no req_ack.
- Overflow: req_wr[0] twice, 2 cycles apart, while downstream is stalled → second pulse dropped, ovf_err[0] = 1, exactly one ds_wr. Re-pulse on the ack edge → accepted, second ds_wr issued.
- ISSUE-cycle ack: ds_ack asserted in the same cycle as ds_wr → completes without entering WAIT; req_ack 1 cycle later; timeout counter unused.
- FLR: sh_cl_flr_assert during WAIT with slot 1 also pending → both slots cleared, no req_ack, state IDLE. A subsequent req_rd[0] completes normally; ovf_err and timeout_cnt unchanged.
